// File: rtl/spi_multi_word_tx.sv
// spi_multi_word_tx: SPI slave transmitter that streams a snapshot of N_WORDS
// words (word 0 first, MSB first) to an MCU over an SPI link that is
// asynchronous to clk.
// Optional feature: define SPI_TX_CHECKSUM_EN to append one extra word holding
// the modulo-2^WORD_W sum of the snapshot.
//
// Handshake: there is no valid/ready pair. A rising edge on done_sig requests
// a snapshot. ready is high while a captured snapshot has not yet been fully
// sent. frame_done pulses for one clk when a frame completes. A request made
// while cs is low is held (one deep) and taken when cs rises.
module spi_multi_word_tx #(
   parameter int N_WORDS  = 20,
   parameter int WORD_W   = 16,
   parameter int SPI_MODE = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      done_sig,
   input  logic [N_WORDS*WORD_W-1:0] data,
   input  logic                      spi_sck,
   input  logic                      spi_cs_n,
   output logic                      spi_miso,
   output logic                      ready,
   output logic                      frame_done,
   output logic [1:0]                dbg_state
);

   localparam bit CPOL = (SPI_MODE & 2) != 0;
   localparam bit CPHA = (SPI_MODE & 1) != 0;
`ifdef SPI_TX_CHECKSUM_EN
   localparam int N_TOTAL = N_WORDS + 1;
`else
   localparam int N_TOTAL = N_WORDS;
`endif
   localparam int WC_W = $clog2(N_TOTAL + 1);
   localparam int BC_W = $clog2(WORD_W);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, END = 2'd3} state_t;

   state_t                    state_q, state_d;
   logic                      sck_meta, sck_s, sck_d;
   logic                      cs_meta, cs_s, cs_d;
   logic                      done_d;
   logic                      sck_rise, sck_fall, lead_edge, trail_edge;
   logic                      sample_edge, launch_edge;
   logic                      cs_rise, cs_fall, done_rise, snap;
   logic                      word_end, last_word, frame_end;
   logic [N_WORDS*WORD_W-1:0] snap_buf_q;
   logic [WORD_W-1:0]         shreg_q, first_word, next_word;
   logic [BC_W-1:0]           bit_cnt_q;
   logic [WC_W-1:0]           word_cnt_q;
   logic                      pend_q;

   // Two-flop synchronisers plus one delay stage for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_meta <= CPOL;
         sck_s    <= CPOL;
         sck_d    <= CPOL;
         cs_meta  <= 1'b1;
         cs_s     <= 1'b1;
         cs_d     <= 1'b1;
         done_d   <= 1'b0;
      end else begin
         sck_meta <= spi_sck;
         sck_s    <= sck_meta;
         sck_d    <= sck_s;
         cs_meta  <= spi_cs_n;
         cs_s     <= cs_meta;
         cs_d     <= cs_s;
         done_d   <= done_sig;
      end
   end

   assign sck_rise    = sck_s & ~sck_d;
   assign sck_fall    = ~sck_s & sck_d;
   assign lead_edge   = CPOL ? sck_fall : sck_rise;
   assign trail_edge  = CPOL ? sck_rise : sck_fall;
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign launch_edge = CPHA ? lead_edge : trail_edge;
   assign cs_rise     = cs_s & ~cs_d;
   assign cs_fall     = ~cs_s & cs_d;
   assign done_rise   = done_sig & ~done_d;
   assign snap        = (done_rise && cs_s) || (cs_rise && pend_q);
   assign word_end    = sample_edge && (bit_cnt_q == BC_W'(WORD_W - 1));
   assign last_word   = word_cnt_q == WC_W'(N_TOTAL - 1);
   assign first_word  = snap_buf_q[WORD_W-1:0];
   assign dbg_state   = state_q;

`ifdef SPI_TX_CHECKSUM_EN
   logic [WORD_W-1:0] chk_q, data_sum;

   // Sum of the incoming words, taken into chk_q together with the snapshot.
   always_comb begin
      data_sum = '0;
      for (int k = 0; k < N_WORDS; k++) data_sum = data_sum + data[k*WORD_W +: WORD_W];
   end

   // Checksum register follows the snapshot buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    chk_q <= '0;
      else if (snap) chk_q <= data_sum;
   end
`endif

   // Word that follows the one currently held in the shift register.
   always_comb begin
      next_word = '0;
      for (int k = 1; k < N_WORDS; k++)
         if (word_cnt_q == WC_W'(k - 1)) next_word = snap_buf_q[k*WORD_W +: WORD_W];
`ifdef SPI_TX_CHECKSUM_EN
      if (word_cnt_q == WC_W'(N_WORDS - 1)) next_word = chk_q;
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; a cs rise from any active state is an abort or frame close.
   always_comb begin
      state_d   = state_q;
      frame_end = 1'b0;
      case (state_q)
         IDLE:    if (cs_fall) state_d = LOAD;
         LOAD:    state_d = cs_rise ? IDLE : SHIFT;
         SHIFT: begin
            if (cs_rise) state_d = IDLE;
            else if (word_end && last_word) begin
               state_d   = END;
               frame_end = 1'b1;
            end
         end
         END:     if (cs_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Snapshot buffer, pending request, ready and frame_done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_buf_q <= '0;
         pend_q     <= 1'b0;
         ready      <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_end;
         if (snap) begin
            snap_buf_q <= data;
            ready      <= 1'b1;
         end else if (frame_end) begin
            ready <= 1'b0;
         end
         if (cs_rise)              pend_q <= 1'b0;
         if (done_rise && !cs_s)   pend_q <= 1'b1;
      end
   end

   // Shift register, bit/word counters and the serial output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         spi_miso   <= 1'b0;
      end else begin
         case (state_q)
            LOAD: begin
               bit_cnt_q  <= '0;
               word_cnt_q <= '0;
               if (cs_rise || CPHA) begin
                  shreg_q  <= first_word;
                  spi_miso <= 1'b0;
               end else begin
                  // CPHA=0: the first bit must already be out before the first sample edge.
                  shreg_q  <= first_word << 1;
                  spi_miso <= first_word[WORD_W-1];
               end
            end
            SHIFT: begin
               if (cs_rise || frame_end) begin
                  spi_miso <= 1'b0;
               end else if (sample_edge) begin
                  if (word_end) begin
                     bit_cnt_q  <= '0;
                     word_cnt_q <= word_cnt_q + WC_W'(1);
                     shreg_q    <= next_word;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BC_W'(1);
                  end
               end else if (launch_edge) begin
                  spi_miso <= shreg_q[WORD_W-1];
                  shreg_q  <= {shreg_q[WORD_W-2:0], 1'b0};
               end
            end
            default: spi_miso <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_multi_word_tx.sv
// tb_spi_multi_word_tx: drives two instances (SPI mode 0 and mode 3) from one
// MCU model; sck for the mode-3 instance is the inverse of the mode-0 sck.
// Honours SPI_TX_CHECKSUM_EN when it is defined for the build.
module tb_spi_multi_word_tx;

   localparam int N = 20;
   localparam int W = 16;
`ifdef SPI_TX_CHECKSUM_EN
   localparam int NT = N + 1;
`else
   localparam int NT = N;
`endif
   localparam int TOTAL_BITS = NT * W;

   // ---------------- clock / reset / DUT ----------------
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         done_sig = 1'b0;
   logic         sck0 = 1'b0;
   logic         cs_n = 1'b1;
   logic         sck3;
   logic [N*W-1:0] data = '0;
   logic         miso0, miso3, ready0, ready3, fd0, fd3;
   logic [1:0]   st0, st3;

   assign sck3 = ~sck0;
   always #5 clk = ~clk;

   spi_multi_word_tx #(.N_WORDS(N), .WORD_W(W), .SPI_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .done_sig(done_sig), .data(data),
      .spi_sck(sck0), .spi_cs_n(cs_n), .spi_miso(miso0), .ready(ready0),
      .frame_done(fd0), .dbg_state(st0));

   spi_multi_word_tx #(.N_WORDS(N), .WORD_W(W), .SPI_MODE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .done_sig(done_sig), .data(data),
      .spi_sck(sck3), .spi_cs_n(cs_n), .spi_miso(miso3), .ready(ready3),
      .frame_done(fd3), .dbg_state(st3));

   // ---------------- model and scoreboard ----------------
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [W-1:0] m_buf[N];
   logic [W-1:0] stage[N];
   logic [W-1:0] m_fill;
   logic         m_ready = 1'b0;
   logic         m_pend = 1'b0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] rx0_q[$];
   logic [W-1:0] rx3_q[$];
   logic [W-1:0] rx0_acc, rx3_acc;
   logic         chk_en = 1'b0;
   logic         idle_chk = 1'b0;
   int           rise_cnt, fall_cnt, fd_cnt0, fd_cnt3, fd_at0, fd_at3;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Frame contents the MCU must see: buffered words, then the sum if enabled.
   task automatic build_exp();
      logic [W-1:0] sum;
      sum = '0;
      exp_q.delete();
      for (int k = 0; k < N; k++) begin
         exp_q.push_back(m_buf[k]);
         sum = sum + m_buf[k];
      end
`ifdef SPI_TX_CHECKSUM_EN
      exp_q.push_back(sum);
`endif
   endtask

   function automatic logic exp_bit(input int idx);
      logic [W-1:0] w;
      if (idx >= TOTAL_BITS) return 1'b0;
      w = exp_q[idx / W];
      return w[W - 1 - (idx % W)];
   endfunction

   // Per-cycle compare: frame_done bookkeeping, ready vs model, miso idle level.
   always @(negedge clk) begin
      if (rst_n) begin
         if (fd0) begin fd_cnt0++; fd_at0 = rise_cnt; end
         if (fd3) begin fd_cnt3++; fd_at3 = fall_cnt; end
         if (chk_en) begin
            check("ready_m0", 32'(ready0), 32'(m_ready));
            check("ready_m3", 32'(ready3), 32'(m_ready));
         end
         if (idle_chk) begin
            check("idle_miso_m0", 32'(miso0), 32'd0);
            check("idle_miso_m3", 32'(miso3), 32'd0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snapshot();
      chk_en = 1'b0;
      for (int k = 0; k < N; k++) data[k*W +: W] = stage[k];
      done_sig = 1'b1;
      wait_clk(3);
      done_sig = 1'b0;
      wait_clk(2);
      for (int k = 0; k < N; k++) m_buf[k] = stage[k];
      m_ready = 1'b1;
      chk_en  = 1'b1;
      wait_clk(2);
   endtask

   // One MCU frame: ncyc sck cycles with half-period hp clk. done_at >= 0 raises
   // done_sig (new data = fill in every word) at that cycle; rst_at >= 0 pulls
   // rst_n at the start of that cycle and ends the frame there.
   task automatic run_frame(input int ncyc, input int hp, input int done_at,
                            input int rst_at, input logic [W-1:0] fill);
      build_exp();
      rx0_q.delete(); rx3_q.delete();
      chk_en = 1'b0; idle_chk = 1'b0;
      rise_cnt = 0; fall_cnt = 0; fd_cnt0 = 0; fd_cnt3 = 0; fd_at0 = -1; fd_at3 = -1;
      @(negedge clk);
      cs_n = 1'b0;
      wait_clk(8);
      for (int c = 0; c < ncyc; c++) begin
         if (c == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            check("rst_mid_miso_m0", 32'(miso0), 32'd0);
            check("rst_mid_miso_m3", 32'(miso3), 32'd0);
            check("rst_mid_ready_m0", 32'(ready0), 32'd0);
            check("rst_mid_ready_m3", 32'(ready3), 32'd0);
            cs_n = 1'b1;
            for (int k = 0; k < N; k++) m_buf[k] = '0;
            m_ready = 1'b0;
            m_pend  = 1'b0;
            wait_clk(3);
            rst_n = 1'b1;
            wait_clk(4);
            chk_en = 1'b1; idle_chk = 1'b1;
            wait_clk(4);
            return;
         end
         if (c == done_at) begin
            data     = {N{fill}};
            m_fill   = fill;
            m_pend   = 1'b1;
            done_sig = 1'b1;
         end
         // sck0 rise: mode-0 sample edge, mode-3 launch edge
         sck0 = 1'b1;
         check($sformatf("bit_m0[%0d]", rise_cnt), 32'(miso0), 32'(exp_bit(rise_cnt)));
         rx0_acc = {rx0_acc[W-2:0], miso0};
         if (rise_cnt % W == W - 1) rx0_q.push_back(rx0_acc);
         rise_cnt++;
         wait_clk(hp);
         done_sig = 1'b0;
         // sck0 fall: mode-3 sample edge (sck3 rises), mode-0 launch edge
         sck0 = 1'b0;
         check($sformatf("bit_m3[%0d]", fall_cnt), 32'(miso3), 32'(exp_bit(fall_cnt)));
         rx3_acc = {rx3_acc[W-2:0], miso3};
         if (fall_cnt % W == W - 1) rx3_q.push_back(rx3_acc);
         fall_cnt++;
         wait_clk(hp);
      end
      wait_clk(4);
      if (ncyc >= TOTAL_BITS) m_ready = 1'b0;
      chk_en = 1'b1;
      wait_clk(2);
      check("fd_count_m0", 32'(fd_cnt0), (ncyc >= TOTAL_BITS) ? 32'd1 : 32'd0);
      check("fd_count_m3", 32'(fd_cnt3), (ncyc >= TOTAL_BITS) ? 32'd1 : 32'd0);
      if (ncyc >= TOTAL_BITS) begin
         check("fd_at_m0", 32'(fd_at0), 32'(TOTAL_BITS));
         check("fd_at_m3", 32'(fd_at3), 32'(TOTAL_BITS));
      end
      chk_en = 1'b0;
      cs_n = 1'b1;
      wait_clk(6);
      if (m_pend) begin
         for (int k = 0; k < N; k++) m_buf[k] = m_fill;
         m_ready = 1'b1;
         m_pend  = 1'b0;
      end
      chk_en = 1'b1; idle_chk = 1'b1;
      wait_clk(4);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   // ---------------- test sequence ----------------
   initial begin
      int kind, hp, extra;
      for (int k = 0; k < N; k++) m_buf[k] = '0;
      rst_n = 1'b0;
      wait_clk(3);
      check("rst_miso_m0", 32'(miso0), 32'd0);
      check("rst_miso_m3", 32'(miso3), 32'd0);
      check("rst_ready_m0", 32'(ready0), 32'd0);
      check("rst_ready_m3", 32'(ready3), 32'd0);
      check("rst_fd_m0", 32'(fd0), 32'd0);
      check("rst_state_m0", 32'(st0), 32'd0);
      check("rst_state_m3", 32'(st3), 32'd0);
      rst_n = 1'b1;
      wait_clk(4);
      chk_en = 1'b1; idle_chk = 1'b1;
      wait_clk(4);

      // Frame with no snapshot since reset: all zeros.
      run_frame(TOTAL_BITS, 4, -1, -1, '0);
      check("zero_word0", 32'(rx0_q[0]), 32'd0);

      // Ramp 0x0100 + k.
      for (int k = 0; k < N; k++) stage[k] = 16'h0100 + 16'(k);
      snapshot();
      run_frame(TOTAL_BITS, 4, -1, -1, '0);
      check("ramp_first_m0", 32'(rx0_q[0]), 32'h0100);
      check("ramp_last_m0", 32'(rx0_q[N-1]), 32'h0113);
      check("ramp_first_m3", 32'(rx3_q[0]), 32'h0100);

      // 0xA5A5 ^ k.
      for (int k = 0; k < N; k++) stage[k] = 16'hA5A5 ^ 16'(k);
      snapshot();
      run_frame(TOTAL_BITS, 4, -1, -1, '0);
      check("a5_word1_m3", 32'(rx3_q[1]), 32'hA5A4);

      // Abort after 37 cycles, then a full frame from word 0.
      for (int k = 0; k < N; k++) stage[k] = 16'h0100 + 16'(k);
      snapshot();
      run_frame(37, 4, -1, -1, '0);
      check("abort_ready_m0", 32'(ready0), 32'd1);
      run_frame(TOTAL_BITS, 4, -1, -1, '0);
      check("restart_word0_m0", 32'(rx0_q[0]), 32'h0100);

      // Snapshot request during a frame: held until cs rises.
      for (int k = 0; k < N; k++) stage[k] = W'($urandom_range(0, 65535));
      snapshot();
      run_frame(TOTAL_BITS, 5, 100, -1, 16'hFFFF);
      check("pend_ready_m0", 32'(ready0), 32'd1);
      run_frame(TOTAL_BITS, 4, -1, -1, '0);
      check("pend_word5_m0", 32'(rx0_q[5]), 32'hFFFF);

      // Reset mid-word, then the next frame is all zeros.
      for (int k = 0; k < N; k++) stage[k] = 16'hFFFF;
      snapshot();
      run_frame(TOTAL_BITS, 4, -1, 40, '0);
      run_frame(TOTAL_BITS, 4, -1, -1, '0);
      check("post_rst_word2_m0", 32'(rx0_q[2]), 32'd0);

`ifdef SPI_TX_CHECKSUM_EN
      for (int k = 0; k < N; k++) stage[k] = 16'(k + 1);
      snapshot();
      run_frame(TOTAL_BITS, 4, -1, -1, '0);
      check("checksum_m0", 32'(rx0_q[N]), 32'h00D2);
      check("checksum_m3", 32'(rx3_q[N]), 32'h00D2);
`endif

      // Randomised frames: full (with extra clocks), aborted, or with a held request.
      for (int it = 0; it < 4; it++) begin
         for (int k = 0; k < N; k++) stage[k] = W'($urandom_range(0, 65535));
         snapshot();
         kind  = $urandom_range(0, 2);
         hp    = $urandom_range(4, 6);
         extra = $urandom_range(0, 2);
         case (kind)
            0:       run_frame(TOTAL_BITS + extra, hp, -1, -1, '0);
            1:       run_frame($urandom_range(1, TOTAL_BITS - 1), hp, -1, -1, '0);
            default: run_frame(TOTAL_BITS, hp, $urandom_range(1, TOTAL_BITS - 1), -1,
                               W'($urandom_range(0, 65535)));
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
